// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared GF(2^31-1) constants, widths and IDLE/RUN state type
package alu_pkg;

    localparam int OPW  = 31;
    localparam int CNTW = 5;

    localparam logic [OPW-1:0]  P        = 31'h7fffffff;
    localparam logic [CNTW-1:0] CNT_INIT = 5'd30;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // All-ones is the second encoding of zero in a Mersenne-prime field.
    function automatic logic [OPW-1:0] canon(input logic [OPW-1:0] x);
        return (x == P) ? '0 : x;
    endfunction

endpackage

// File: rtl/mod_add.sv
// rtl/mod_add.sv - combinational 31-bit addition modulo 2^31-1, canonical result
module mod_add
    import alu_pkg::*;
(
    input  logic [OPW-1:0] i_x,
    input  logic [OPW-1:0] i_y,
    output logic [OPW-1:0] o_sum
);

    logic [OPW:0]   w_sum;
    logic [OPW-1:0] w_fold;

    // 2^31 == 1 mod p, so the carry folds back into bit 0; inputs below p keep this from overflowing.
    assign w_sum  = {1'b0, i_x} + {1'b0, i_y};
    assign w_fold = w_sum[OPW-1:0] + {{(OPW-1){1'b0}}, w_sum[OPW]};
    assign o_sum  = canon(w_fold);

endmodule

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - sequential shift-add multiplier in GF(2^31-1); MOD_MUL_EARLY_EXIT_EN enables early completion
module mod_mul
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [OPW-1:0] _mul,
    output logic           _rdy
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic [OPW-1:0]  r_acc;
    logic [OPW-1:0]  r_mul;
    logic [CNTW-1:0] r_cnt;

    logic [OPW-1:0]  w_add_sum;
    logic [OPW-1:0]  w_acc_nxt;
    logic [OPW-1:0]  w_a_dbl;
    logic [OPW-1:0]  w_b_shr;
    logic            w_last;

    mod_add u_mod_add (
        .i_x   (r_acc),
        .i_y   (r_a),
        .o_sum (w_add_sum)
    );

    assign w_acc_nxt = r_b[0] ? w_add_sum : r_acc;
    assign w_a_dbl   = canon({r_a[OPW-2:0], r_a[OPW-1]});
    assign w_b_shr   = r_b >> 1;

`ifdef MOD_MUL_EARLY_EXIT_EN
    assign w_last = (r_cnt == '0) || (w_b_shr == '0);
`else
    assign w_last = (r_cnt == '0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        _rdy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end else begin
                    _rdy = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    w_state_nxt = RUN;
                end else if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A start in RUN simply reloads the operands, silently dropping the old job.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_mul <= '0;
        end else if (start) begin
            r_a   <= canon(a);
            r_b   <= canon(b);
            r_acc <= '0;
            r_cnt <= CNT_INIT;
        end else if (r_state == RUN) begin
            r_acc <= w_acc_nxt;
            r_a   <= w_a_dbl;
            r_b   <= w_b_shr;
            if (w_last) begin
                r_mul <= w_acc_nxt;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign _mul = r_mul;

endmodule

// File: tb/tb_mod_mul.sv
// tb/tb_mod_mul.sv - randomized self-checking bench for mod_mul against a plain-arithmetic model
module tb_mod_mul;

    logic        clk;
    logic        reset;
    logic        start;
    logic [30:0] a;
    logic [30:0] b;
    logic [30:0] mul_o;
    logic        rdy_o;

    int total;
    int bad;

    localparam logic [30:0]     PV = 31'h7fffffff;
    localparam longint unsigned PM = 64'h7fffffff;

    mod_mul dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        ._mul  (mul_o),
        ._rdy  (rdy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [30:0] ref_mul(input logic [30:0] x, input logic [30:0] y);
        longint unsigned cx;
        longint unsigned cy;
        cx = (x == PV) ? 64'd0 : {33'd0, x};
        cy = (y == PV) ? 64'd0 : {33'd0, y};
        return 31'((cx * cy) % PM);
    endfunction

    function automatic int exp_lat(input logic [30:0] y);
`ifdef MOD_MUL_EARLY_EXIT_EN
        logic [30:0] cy;
        cy = (y == PV) ? 31'd0 : y;
        if (cy == 31'd0) return 1;
        for (int i = 30; i >= 0; i--) begin
            if (cy[i]) return i + 1;
        end
        return 1;
`else
        return 31 + 0 * int'(y[0]);
`endif
    endfunction

    task automatic run_op(input logic [30:0] x, input logic [30:0] y,
                          output int lat, output bit held_ok, output bit comb_ok);
        logic [30:0] prev;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        #1;
        comb_ok = (rdy_o === 1'b0);
        prev = mul_o;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        held_ok = 1'b1;
        while (rdy_o !== 1'b1 && lat < 200) begin
            lat++;
            if (mul_o !== prev) held_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        a = 31'd5;
        b = 31'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (mul_o !== 31'd0) begin bad++; $display("FAIL reset_mul got=%0h exp=0", mul_o); end
        total++;
        if (rdy_o !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%0b exp=1", rdy_o); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (rdy_o !== 1'b1 || mul_o !== 31'd0) begin
            bad++; $display("FAIL reset_idle rdy=%0b mul=%0h exp rdy=1 mul=0", rdy_o, mul_o);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit held_ok;
        bit comb_ok;
        run_op(31'd3, 31'd5, lat, held_ok, comb_ok);
        total++;
        if (comb_ok !== 1'b1) begin bad++; $display("FAIL basic_comb_rdy got=%0b exp=1", comb_ok); end
        total++;
        if (lat != exp_lat(31'd5)) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, exp_lat(31'd5)); end
        total++;
        if (held_ok !== 1'b1) begin bad++; $display("FAIL basic_hold got=%0b exp=1", held_ok); end
        total++;
        if (mul_o !== 31'd15 || rdy_o !== 1'b1) begin
            bad++; $display("FAIL basic_result mul=%0d rdy=%0b exp mul=15 rdy=1", mul_o, rdy_o);
        end
    endtask

    task automatic test_corners();
        logic [30:0] xs [6];
        logic [30:0] ys [6];
        logic [30:0] es [6];
        int lat;
        bit held_ok;
        bit comb_ok;
        xs = '{31'h7ffffffe, 31'h40000000, 31'h7fffffff, 31'd7,        31'd0,        31'h7ffffffe};
        ys = '{31'h7ffffffe, 31'd2,        31'd12345,    31'h7fffffff, 31'h1234567,  31'd1};
        es = '{31'd1,        31'd1,        31'd0,        31'd0,        31'd0,        31'h7ffffffe};
        for (int i = 0; i < 6; i++) begin
            run_op(xs[i], ys[i], lat, held_ok, comb_ok);
            total++;
            if (mul_o !== es[i] || lat != exp_lat(ys[i])) begin
                bad++;
                $display("FAIL corner%0d mul=%0h lat=%0d exp mul=%0h lat=%0d", i, mul_o, lat, es[i], exp_lat(ys[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [30:0] x;
        logic [30:0] y;
        int lat;
        bit held_ok;
        bit comb_ok;
        for (int i = 0; i < 24; i++) begin
            x = 31'($urandom);
            y = 31'($urandom);
            if ($urandom_range(0, 7) == 0) x = PV;
            if ($urandom_range(0, 7) == 1) y = PV;
            if ($urandom_range(0, 3) == 2) y = 31'($urandom_range(0, 255));
            run_op(x, y, lat, held_ok, comb_ok);
            total++;
            if (mul_o !== ref_mul(x, y) || lat != exp_lat(y) || !held_ok) begin
                bad++;
                $display("FAIL random%0d a=%0h b=%0h mul=%0h lat=%0d hold=%0b exp mul=%0h lat=%0d hold=1",
                         i, x, y, mul_o, lat, held_ok, ref_mul(x, y), exp_lat(y));
            end
        end
    endtask

    task automatic test_restart();
        int lat;
        bit held_ok;
        bit comb_ok;
        bit saw15;
        run_op(31'd2, 31'd3, lat, held_ok, comb_ok);
        total++;
        if (mul_o !== 31'd6) begin bad++; $display("FAIL restart_pre got=%0d exp=6", mul_o); end
        saw15 = 1'b0;
        @(negedge clk);
        a = 31'd3;
        b = 31'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mul_o === 31'd15) saw15 = 1'b1;
        end
        a = 31'd6;
        b = 31'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (rdy_o !== 1'b1 && lat < 200) begin
            lat++;
            if (mul_o === 31'd15) saw15 = 1'b1;
            @(negedge clk);
        end
`ifndef MOD_MUL_EARLY_EXIT_EN
        total++;
        if (saw15) begin bad++; $display("FAIL restart_no_partial got=1 exp=0"); end
`endif
        total++;
        if (lat != exp_lat(31'd7)) begin bad++; $display("FAIL restart_latency got=%0d exp=%0d", lat, exp_lat(31'd7)); end
        total++;
        if (mul_o !== 31'd42) begin bad++; $display("FAIL restart_result got=%0d exp=42", mul_o); end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit held_ok;
        bit comb_ok;
        bit wrote;
        run_op(31'd11, 31'd13, lat, held_ok, comb_ok);
        total++;
        if (mul_o !== 31'd143) begin bad++; $display("FAIL abort_pre got=%0d exp=143", mul_o); end
        @(negedge clk);
        a = 31'd3;
        b = 31'h40000001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (rdy_o !== 1'b1 || mul_o !== 31'd0) begin
            bad++; $display("FAIL abort_release rdy=%0b mul=%0h exp rdy=1 mul=0", rdy_o, mul_o);
        end
        wrote = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (mul_o !== 31'd0 || rdy_o !== 1'b1) wrote = 1'b1;
        end
        total++;
        if (wrote) begin bad++; $display("FAIL abort_no_result got=1 exp=0"); end
    endtask

    task automatic test_early_exit();
        int lat;
        bit held_ok;
        bit comb_ok;
        run_op(31'd9, 31'd1, lat, held_ok, comb_ok);
        total++;
        if (mul_o !== 31'd9 || lat != exp_lat(31'd1)) begin
            bad++; $display("FAIL early_b1 mul=%0d lat=%0d exp mul=9 lat=%0d", mul_o, lat, exp_lat(31'd1));
        end
        run_op(31'd77, 31'd0, lat, held_ok, comb_ok);
        total++;
        if (mul_o !== 31'd0 || lat != exp_lat(31'd0)) begin
            bad++; $display("FAIL early_b0 mul=%0d lat=%0d exp mul=0 lat=%0d", mul_o, lat, exp_lat(31'd0));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_restart();
        test_reset_abort();
        test_early_exit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_mul.md
MOD_MUL -- requirements
Module: mod_mul

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, active-low synchronous reset sampled on the clk rising edge.
REQ-003 SHALL have port start, input, 1, request pulse that latches operands and begins a multiplication.
REQ-004 SHALL have port a, input, 31, multiplicand, an element of GF(p) with p = 2^31-1.
REQ-005 SHALL have port b, input, 31, multiplier, an element of GF(p).
REQ-006 SHALL have port _mul, output, 31, registered product a*b mod p in canonical form 0..p-1.
REQ-007 SHALL have port _rdy, output, 1, high when idle with _mul valid, low while busy.

Function
REQ-008 SHALL treat operand value 31'h7fffffff as 0 (non-canonical zero) on latch.
REQ-009 SHALL implement states IDLE and RUN; IDLE->RUN on start; RUN->IDLE on final iteration; RUN->RUN on start (restart).
REQ-010 SHALL on a start edge latch A<=a, B<=b, ACC<=0, CNT<=30, enter RUN, for start sampled in either state.
REQ-011 SHALL per RUN edge use LSB-first shift-add: if B[0], ACC<=(ACC+A) mod p; A<=2A mod p; B<=B>>1; CNT<=CNT-1.
REQ-012 SHALL compute 2A mod p as left-rotate by one bit, forcing 31'h7fffffff to 0.
REQ-013 SHALL compute modular add as 32-bit sum folded (low 31 bits + carry), forcing 31'h7fffffff to 0.
REQ-014 SHALL on the RUN edge with CNT==0 write the final ACC to _mul and return to IDLE; latency 31 RUN edges after the start edge.
REQ-015 SHALL hold _mul at its previous value from start until completion; never expose partial ACC.
REQ-016 SHALL drive _rdy low combinationally in an IDLE cycle where start is high, low throughout RUN, high from the edge that writes _mul.
REQ-017 SHALL discard the in-flight operation without updating _mul when start arrives during RUN.

Reset
REQ-018 SHALL with reset low at a clk edge set state IDLE, _mul=0, ACC=0, A=0, B=0, CNT=0, regardless of start.
REQ-019 SHALL abort any RUN operation on reset without writing a result; _rdy high in the first cycle after release.

Configuration
REQ-020 SHALL with MOD_MUL_EARLY_EXIT_EN defined complete on the first RUN edge where the shifted B (B>>1) is zero or CNT==0, writing the updated ACC; b=0 completes after one RUN edge.
REQ-021 SHALL without MOD_MUL_EARLY_EXIT_EN always take exactly 31 RUN edges; results identical in both builds.

Structure
REQ-022 SHALL place constant P (31'h7fffffff), operand width (31), counter width (5) and the IDLE/RUN state typedef in shared package alu_pkg, reused by the divider.
REQ-023 SHALL instantiate one sub-module mod_add (combinational 31-bit addition mod p, canonical output) for the accumulate step.

Verification
REQ-024 SHALL test a=3, b=5, start one cycle -> _rdy low 31 cycles, then _mul=15, _rdy=1 (fixed-latency build).
REQ-025 SHALL test a=b=31'h7ffffffe -> _mul=1; a=31'h40000000, b=2 -> _mul=1.
REQ-026 SHALL test a=31'h7fffffff, b=12345 -> _mul=0; a=7, b=31'h7fffffff -> _mul=0.
REQ-027 SHALL test start a=3,b=5, restart at RUN cycle 10 with a=6,b=7 -> _mul=42 exactly 31 edges after the second start, no intermediate 15.
REQ-028 SHALL test reset low at RUN cycle 5 -> _mul=0, _rdy=1 after release; with MOD_MUL_EARLY_EXIT_EN, a=9,b=1 -> _mul=9 after one RUN edge.
